// File: rtl/id_ex_decode.sv
// Instruction decode stage plus ID/EX pipeline register for the RV32I core.
// Decodes the IF/ID instruction into the execute-stage control bundle, registers
// it into EX, detects load-use hazards against the held EX instruction and turns
// flushed, stalled, invalid or (optionally) illegal instructions into bubbles.
//
// Ports:
//   clk, rst_n          core clock, asynchronous active-low reset
//   if_valid/inst/pc    instruction presented by IF/ID
//   flush               taken branch/jump in EX; kill the ID instruction
//   id_stall            combinational load-use stall request to PC and IF/ID
//   ex_*                registered control bundle for the execute stage
module id_ex_decode #(
  parameter bit HAZARD_EN    = 1'b1,
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_inst,
  input  logic [31:0] if_pc,
  input  logic        flush,
  output logic        id_stall,
  output logic        ex_valid,
  output logic [3:0]  ex_alu_sel,
  output logic        ex_b_sel,
  output logic        ex_a_sel,
  output logic [4:0]  ex_shamt,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [4:0]  ex_rd,
  output logic [2:0]  ex_funct3,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_branch,
  output logic        ex_jal,
  output logic        ex_jalr,
  output logic [31:0] ex_pc,
  output logic        ex_illegal
);

  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  localparam logic [3:0] AluAdd   = 4'd0;
  localparam logic [3:0] AluSub   = 4'd1;
  localparam logic [3:0] AluXor   = 4'd2;
  localparam logic [3:0] AluOr    = 4'd3;
  localparam logic [3:0] AluAnd   = 4'd4;
  localparam logic [3:0] AluSll   = 4'd5;
  localparam logic [3:0] AluSrl   = 4'd6;
  localparam logic [3:0] AluSra   = 4'd7;
  localparam logic [3:0] AluSlt   = 4'd8;
  localparam logic [3:0] AluSltu  = 4'd9;
  localparam logic [3:0] AluPassB = 4'd10;
  localparam logic [3:0] AluAddPc = 4'd11;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rs1, rs2, rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = if_inst[6:0];
  assign rd     = if_inst[11:7];
  assign funct3 = if_inst[14:12];
  assign rs1    = if_inst[19:15];
  assign rs2    = if_inst[24:20];
  assign funct7 = if_inst[31:25];

  assign imm_i = {{20{if_inst[31]}}, if_inst[31:20]};
  assign imm_s = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
  assign imm_b = {{19{if_inst[31]}}, if_inst[31], if_inst[7], if_inst[30:25], if_inst[11:8], 1'b0};
  assign imm_u = {if_inst[31:12], 12'h000};
  assign imm_j = {{11{if_inst[31]}}, if_inst[31], if_inst[19:12], if_inst[20], if_inst[30:21],
                  1'b0};

  // Base ALU op for a funct3 in the OP / OP-IMM groups (funct7 variants handled by caller).
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3);
    case (f3)
      3'd0:    alu_from_f3 = AluAdd;
      3'd1:    alu_from_f3 = AluSll;
      3'd2:    alu_from_f3 = AluSlt;
      3'd3:    alu_from_f3 = AluSltu;
      3'd4:    alu_from_f3 = AluXor;
      3'd5:    alu_from_f3 = AluSrl;
      3'd6:    alu_from_f3 = AluOr;
      default: alu_from_f3 = AluAnd;
    endcase
  endfunction

  logic [3:0]  dec_alu;
  logic [31:0] dec_imm;
  logic        dec_b_sel, dec_a_sel, dec_rw, dec_mr, dec_mw, dec_br, dec_jal, dec_jalr;
  logic        dec_illegal, uses_rs1, uses_rs2;

  always_comb begin
    dec_alu     = AluAdd;
    dec_imm     = '0;
    dec_b_sel   = 1'b0;
    dec_a_sel   = 1'b0;
    dec_rw      = 1'b0;
    dec_mr      = 1'b0;
    dec_mw      = 1'b0;
    dec_br      = 1'b0;
    dec_jal     = 1'b0;
    dec_jalr    = 1'b0;
    dec_illegal = 1'b0;
    uses_rs1    = 1'b0;
    uses_rs2    = 1'b0;
    case (opcode)
      OpReg: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        dec_rw   = 1'b1;
        if (funct7 == F7Alt && (funct3 == 3'd0 || funct3 == 3'd5)) begin
          dec_alu = (funct3 == 3'd0) ? AluSub : AluSra;
        end else if (funct7 == F7Base) begin
          dec_alu = alu_from_f3(funct3);
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OpImm: begin
        uses_rs1  = 1'b1;
        dec_rw    = 1'b1;
        dec_b_sel = 1'b1;
        dec_imm   = imm_i;
        dec_alu   = alu_from_f3(funct3);
        if (funct3 == 3'd1 && funct7 != F7Base) dec_illegal = 1'b1;
        if (funct3 == 3'd5) begin
          if (funct7 == F7Alt)       dec_alu     = AluSra;
          else if (funct7 != F7Base) dec_illegal = 1'b1;
        end
      end
      OpLoad: begin
        uses_rs1    = 1'b1;
        dec_b_sel   = 1'b1;
        dec_imm     = imm_i;
        dec_mr      = 1'b1;
        dec_rw      = 1'b1;
        // lb, lh, lw, lbu, lhu only.
        dec_illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
      end
      OpStore: begin
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b1;
        dec_b_sel   = 1'b1;
        dec_imm     = imm_s;
        dec_mw      = 1'b1;
        dec_illegal = funct3[2] || (funct3 == 3'd3);
      end
      OpBranch: begin
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b1;
        dec_alu     = AluSub;
        dec_imm     = imm_b;
        dec_br      = 1'b1;
        dec_illegal = (funct3 == 3'd2) || (funct3 == 3'd3);
      end
      OpLui: begin
        dec_alu   = AluPassB;
        dec_b_sel = 1'b1;
        dec_imm   = imm_u;
        dec_rw    = 1'b1;
      end
      OpAuipc: begin
        dec_alu   = AluAddPc;
        dec_a_sel = 1'b1;
        dec_b_sel = 1'b1;
        dec_imm   = imm_u;
        dec_rw    = 1'b1;
      end
      OpJal: begin
        // ALU forms the target pc+imm; the link value pc+4 is built in EX.
        dec_alu   = AluAddPc;
        dec_a_sel = 1'b1;
        dec_b_sel = 1'b1;
        dec_imm   = imm_j;
        dec_jal   = 1'b1;
        dec_rw    = 1'b1;
      end
      OpJalr: begin
        uses_rs1    = 1'b1;
        dec_b_sel   = 1'b1;
        dec_imm     = imm_i;
        dec_jalr    = 1'b1;
        dec_rw      = 1'b1;
        dec_illegal = (funct3 != 3'd0);
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  logic rs_hit;
  assign rs_hit   = (uses_rs1 && rs1 == ex_rd) || (uses_rs2 && rs2 == ex_rd);
  assign id_stall = HAZARD_EN && !flush && if_valid && ex_valid && ex_mem_read &&
                    (ex_rd != 5'd0) && rs_hit;

  // Next-state bundle: either a decoded instruction, an illegal trap marker or a bubble.
  logic        load_inst, trap;
  logic        valid_d, b_sel_d, a_sel_d, rw_d, mr_d, mw_d, br_d, jal_d, jalr_d, illegal_d;
  logic [3:0]  alu_d;
  logic [4:0]  shamt_d, rs1_d, rs2_d, rd_d;
  logic [2:0]  funct3_d;
  logic [31:0] imm_d, pc_d;

  assign load_inst = if_valid && !flush && !id_stall && (!dec_illegal || ILLEGAL_TRAP);
  assign trap      = dec_illegal;

  always_comb begin
    valid_d   = 1'b0;
    alu_d     = '0;
    b_sel_d   = 1'b0;
    a_sel_d   = 1'b0;
    shamt_d   = '0;
    imm_d     = '0;
    rs1_d     = '0;
    rs2_d     = '0;
    rd_d      = '0;
    funct3_d  = '0;
    rw_d      = 1'b0;
    mr_d      = 1'b0;
    mw_d      = 1'b0;
    br_d      = 1'b0;
    jal_d     = 1'b0;
    jalr_d    = 1'b0;
    pc_d      = '0;
    illegal_d = 1'b0;
    if (load_inst) begin
      valid_d   = 1'b1;
      shamt_d   = rs2;
      rs1_d     = rs1;
      rs2_d     = rs2;
      rd_d      = rd;
      funct3_d  = funct3;
      pc_d      = if_pc;
      illegal_d = trap;
      // An illegal instruction carries only its identity (pc, fields) into EX.
      if (!trap) begin
        alu_d   = dec_alu;
        b_sel_d = dec_b_sel;
        a_sel_d = dec_a_sel;
        imm_d   = dec_imm;
        rw_d    = dec_rw && (rd != 5'd0);
        mr_d    = dec_mr;
        mw_d    = dec_mw;
        br_d    = dec_br;
        jal_d   = dec_jal;
        jalr_d  = dec_jalr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_alu_sel   <= '0;
      ex_b_sel     <= 1'b0;
      ex_a_sel     <= 1'b0;
      ex_shamt     <= '0;
      ex_imm       <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_funct3    <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_branch    <= 1'b0;
      ex_jal       <= 1'b0;
      ex_jalr      <= 1'b0;
      ex_pc        <= '0;
      ex_illegal   <= 1'b0;
    end else begin
      ex_valid     <= valid_d;
      ex_alu_sel   <= alu_d;
      ex_b_sel     <= b_sel_d;
      ex_a_sel     <= a_sel_d;
      ex_shamt     <= shamt_d;
      ex_imm       <= imm_d;
      ex_rs1       <= rs1_d;
      ex_rs2       <= rs2_d;
      ex_rd        <= rd_d;
      ex_funct3    <= funct3_d;
      ex_reg_write <= rw_d;
      ex_mem_read  <= mr_d;
      ex_mem_write <= mw_d;
      ex_branch    <= br_d;
      ex_jal       <= jal_d;
      ex_jalr      <= jalr_d;
      ex_pc        <= pc_d;
      ex_illegal   <= illegal_d;
    end
  end

endmodule

// File: tb/tb_id_ex_decode.sv
module tb_id_ex_decode;

  typedef struct packed {
    logic        valid;
    logic [3:0]  alu;
    logic        b_sel;
    logic        a_sel;
    logic [4:0]  shamt;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        br;
    logic        jal;
    logic        jalr;
    logic [31:0] pc;
    logic        ill;
  } bundle_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic if_valid = 1'b0;
  logic [31:0] if_inst = '0;
  logic [31:0] if_pc = '0;
  logic flush = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // dut1: hazard detection on, illegal trap on.  dut0: both off.
  logic        st1, v1, b1, a1, rw1, mr1, mw1, br1, j1, jr1, il1;
  logic [3:0]  alu1;
  logic [4:0]  sh1, r1a, r2a, rda;
  logic [2:0]  f31;
  logic [31:0] imm1, pc1;
  logic        st0, v0, b0, a0, rw0, mr0, mw0, br0, j0, jr0, il0;
  logic [3:0]  alu0;
  logic [4:0]  sh0, r1b, r2b, rdb;
  logic [2:0]  f30;
  logic [31:0] imm0, pc0;

  id_ex_decode #(.HAZARD_EN(1'b1), .ILLEGAL_TRAP(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .flush(flush), .id_stall(st1), .ex_valid(v1), .ex_alu_sel(alu1), .ex_b_sel(b1),
    .ex_a_sel(a1), .ex_shamt(sh1), .ex_imm(imm1), .ex_rs1(r1a), .ex_rs2(r2a), .ex_rd(rda),
    .ex_funct3(f31), .ex_reg_write(rw1), .ex_mem_read(mr1), .ex_mem_write(mw1),
    .ex_branch(br1), .ex_jal(j1), .ex_jalr(jr1), .ex_pc(pc1), .ex_illegal(il1)
  );

  id_ex_decode #(.HAZARD_EN(1'b0), .ILLEGAL_TRAP(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .flush(flush), .id_stall(st0), .ex_valid(v0), .ex_alu_sel(alu0), .ex_b_sel(b0),
    .ex_a_sel(a0), .ex_shamt(sh0), .ex_imm(imm0), .ex_rs1(r1b), .ex_rs2(r2b), .ex_rd(rdb),
    .ex_funct3(f30), .ex_reg_write(rw0), .ex_mem_read(mr0), .ex_mem_write(mw0),
    .ex_branch(br0), .ex_jal(j0), .ex_jalr(jr0), .ex_pc(pc0), .ex_illegal(il0)
  );

  bundle_t got1, got0;
  assign got1 = {v1, alu1, b1, a1, sh1, imm1, r1a, r2a, rda, f31, rw1, mr1, mw1, br1, j1, jr1,
                 pc1, il1};
  assign got0 = {v0, alu0, b0, a0, sh0, imm0, r1b, r2b, rdb, f30, rw0, mr0, mw0, br0, j0, jr0,
                 pc0, il0};

  bundle_t q1[$];
  bundle_t q0[$];
  bundle_t m1, m0;  // model of what each ID/EX register holds

  // Reference decode: what EX should hold after accepting instruction i.
  function automatic bundle_t ref_decode(logic [31:0] i, logic [31:0] pc, bit trap);
    bundle_t b = '0;
    bit ill = 1'b0;
    logic [6:0] op = i[6:0];
    logic [2:0] f3 = i[14:12];
    logic [6:0] f7 = i[31:25];
    logic [3:0] f3_alu [8] = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd2, 4'd6, 4'd3, 4'd4};
    int si, ss, sb, sj;
    si = $signed(i[31:20]);
    ss = $signed({i[31:25], i[11:7]});
    sb = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
    sj = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
    case (op)
      7'h33: begin
        b.rw = 1;
        if (f7 == 7'h00) b.alu = f3_alu[f3];
        else if (f7 == 7'h20 && f3 == 0) b.alu = 4'd1;
        else if (f7 == 7'h20 && f3 == 5) b.alu = 4'd7;
        else ill = 1;
      end
      7'h13: begin
        b.rw = 1; b.b_sel = 1; b.imm = si; b.alu = f3_alu[f3];
        if (f3 == 1 && f7 != 0) ill = 1;
        if (f3 == 5) begin
          if (f7 == 7'h20) b.alu = 4'd7;
          else if (f7 != 0) ill = 1;
        end
      end
      7'h03: begin
        b.rw = 1; b.mr = 1; b.b_sel = 1; b.imm = si;
        ill = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      end
      7'h23: begin b.mw = 1; b.b_sel = 1; b.imm = ss; ill = (f3 > 2); end
      7'h63: begin b.br = 1; b.alu = 4'd1; b.imm = sb; ill = (f3 == 2 || f3 == 3); end
      7'h37: begin b.alu = 4'd10; b.b_sel = 1; b.rw = 1; b.imm = {i[31:12], 12'h0}; end
      7'h17: begin
        b.alu = 4'd11; b.a_sel = 1; b.b_sel = 1; b.rw = 1; b.imm = {i[31:12], 12'h0};
      end
      7'h6F: begin
        b.alu = 4'd11; b.a_sel = 1; b.b_sel = 1; b.rw = 1; b.jal = 1; b.imm = sj;
      end
      7'h67: begin b.b_sel = 1; b.jalr = 1; b.rw = 1; b.imm = si; ill = (f3 != 0); end
      default: ill = 1;
    endcase
    if (i[11:7] == 0) b.rw = 0;
    if (ill) begin
      if (!trap) return '0;
      b = '0;
      b.ill = 1;
    end
    b.valid = 1; b.shamt = i[24:20]; b.rs1 = i[19:15]; b.rs2 = i[24:20]; b.rd = i[11:7];
    b.f3 = f3; b.pc = pc;
    return b;
  endfunction

  function automatic bit ref_stall(bundle_t held, logic v, logic [31:0] i, logic fl);
    logic [6:0] op = i[6:0];
    bit u1 = op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
    bit u2 = op inside {7'h33, 7'h23, 7'h63};
    if (!v || fl || !held.valid || !held.mr || held.rd == 0) return 0;
    return (u1 && i[19:15] == held.rd) || (u2 && i[24:20] == held.rd);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  // One ID cycle: drive at negedge, check stall, queue the expected EX contents.
  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic fl, output bit stalled);
    bit s1;
    @(negedge clk);
    if_valid = v; if_inst = inst; if_pc = pc; flush = fl;
    #1;
    s1 = ref_stall(m1, v, inst, fl);
    chk("id_stall_dut1", {31'b0, st1}, {31'b0, s1});
    chk("id_stall_dut0", {31'b0, st0}, 32'd0);
    m1 = (fl || s1 || !v) ? '0 : ref_decode(inst, pc, 1'b1);
    m0 = (fl || !v) ? '0 : ref_decode(inst, pc, 1'b0);
    q1.push_back(m1);
    q0.push_back(m0);
    stalled = s1;
    @(posedge clk);
    #2;
  endtask

  // Monitor: one EX bundle per edge while out of reset.
  initial begin
    bundle_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && q1.size() > 0) begin
        e = q1.pop_front();
        checks++;
        if (got1 !== e) begin
          failures++;
          $display("FAIL ex_bundle_dut1 got=%h expected=%h", got1, e);
        end
      end
      if (rst_n && q0.size() > 0) begin
        e = q0.pop_front();
        checks++;
        if (got0 !== e) begin
          failures++;
          $display("FAIL ex_bundle_dut0 got=%h expected=%h", got0, e);
        end
      end
    end
  end

  function automatic logic [31:0] rand_inst();
    logic [4:0] rd = 5'($urandom_range(0, 7));
    logic [4:0] ra = 5'($urandom_range(0, 7));
    logic [4:0] rb = 5'($urandom_range(0, 7));
    logic [2:0] f3 = 3'($urandom_range(0, 7));
    logic [31:0] r = $urandom;
    logic [6:0] f7;
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h20;
      default: f7 = r[31:25];
    endcase
    case ($urandom_range(0, 9))
      0: return {f7, rb, ra, f3, rd, 7'h33};
      1: return {f7, rb, ra, f3, rd, 7'h13};
      2: return {r[31:20], ra, f3, rd, 7'h03};
      3: return {r[31:25], rb, ra, f3, r[11:7], 7'h23};
      4: return {r[31:25], rb, ra, f3, r[11:7], 7'h63};
      5: return {r[31:12], rd, 7'h37};
      6: return {r[31:12], rd, 7'h17};
      7: return {r[31:12], rd, 7'h6F};
      8: return {r[31:20], ra, (r[0] ? 3'd0 : f3), rd, 7'h67};
      default: return r;
    endcase
  endfunction

  initial begin
    bit s;
    logic [31:0] inst, pc;
    m1 = '0;
    m0 = '0;
    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset_bundle_dut1", {31'b0, got1 == '0}, 32'd1);
    chk("reset_bundle_dut0", {31'b0, got0 == '0}, 32'd1);
    chk("reset_stall", {30'b0, st1, st0}, 32'd0);
    rst_n = 1'b1;

    // addi x5,x1,-3 then srai x2,x3,7.
    step(1, 32'hFFD08293, 32'h40, 0, s);
    chk("addi_imm", imm1, 32'hFFFFFFFD);
    chk("addi_rd_rw", {26'b0, rda, rw1}, {26'b0, 5'd5, 1'b1});
    step(1, 32'h4071D113, 32'h44, 0, s);
    chk("srai_alu_shamt_bsel", {22'b0, alu1, sh1, b1}, {22'b0, 4'd7, 5'd7, 1'b1});

    // Asynchronous reset mid-cycle with a valid instruction held.
    chk("pre_reset_valid", {31'b0, v1}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", {30'b0, v1, v0}, 32'd0);
    chk("async_reset_bundle", {31'b0, got1 == '0}, 32'd1);
    m1 = '0;
    m0 = '0;
    @(negedge clk);
    if_valid = 0;
    rst_n = 1'b1;

    // Load-use: lw x6,0(x2); add x7,x6,x1 stalls exactly once.
    step(1, 32'h00012303, 32'h100, 0, s);
    step(1, 32'h001303B3, 32'h104, 0, s);
    chk("load_use_stall", {31'b0, s}, 32'd1);
    chk("load_use_bubble", {31'b0, v1}, 32'd0);
    step(1, 32'h001303B3, 32'h104, 0, s);
    chk("load_use_release", {31'b0, s}, 32'd0);
    // rd=x0 never stalls.
    step(1, 32'h00012003, 32'h108, 0, s);
    step(1, 32'h001003B3, 32'h10C, 0, s);
    chk("load_x0_no_stall", {31'b0, s}, 32'd0);
    // Flush beats a hazard: sub x3,x6,x5 behind lw x6.
    step(1, 32'h00012303, 32'h110, 0, s);
    step(1, 32'h405301B3, 32'h114, 1, s);
    chk("flush_no_stall", {31'b0, s}, 32'd0);
    chk("flush_bubble", {31'b0, v1}, 32'd0);
    // lui / auipc.
    step(1, 32'h123450B7, 32'h118, 0, s);
    chk("lui_alu_imm", {alu1, imm1[27:0]}, {4'd10, 28'h2345000});
    step(1, 32'h00001117, 32'h100, 0, s);
    chk("auipc_alu_asel_pc", {alu1, a1, pc1[26:0]}, {4'd11, 1'b1, 27'h100});
    // Illegal encodings.
    step(1, 32'h0000007F, 32'h120, 0, s);
    chk("illegal_op_trap", {29'b0, v1, il1, rw1}, {29'b0, 3'b110});
    chk("illegal_op_bubble", {31'b0, v0}, 32'd0);
    step(1, 32'h023100B3, 32'h124, 0, s);
    chk("illegal_f7_trap", {29'b0, v1, il1, rw1}, {29'b0, 3'b110});
    chk("illegal_f7_bubble", {31'b0, v0}, 32'd0);

    // Randomized traffic; a stalled instruction is re-presented by IF.
    pc = 32'h1000;
    inst = rand_inst();
    s = 0;
    for (int n = 0; n < 600; n++) begin
      logic v, fl;
      if (!s) begin
        inst = rand_inst();
        pc = pc + 4;
        v = ($urandom_range(0, 9) != 0);
      end else begin
        v = 1'b1;
      end
      fl = ($urandom_range(0, 9) == 0);
      step(v, inst, pc, fl, s);
    end

    @(negedge clk);
    if_valid = 0;
    repeat (4) @(posedge clk);
    #3;
    chk("scoreboard_drained", q1.size() + q0.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
